// File: rtl/dff_pipe.sv
// Parameterised register pipeline with per-stage valid, rotate mode,
// synchronous clear, stage tap and registered fill count.
module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int TSW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             recirc,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [TSW-1:0]   tap_sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [WIDTH-1:0] tap_q,
  output logic             tap_valid,
  output logic [CW-1:0]    fill_cnt,
  output logic             full
);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
      vld <= '0;
      cnt <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
      vld <= '0;
      cnt <= '0;
    end else if (en) begin
      data[0] <= recirc ? data[DEPTH-1] : d;
      vld[0]  <= recirc ? vld[DEPTH-1] : d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data[i] <= data[i-1];
        vld[i]  <= vld[i-1];
      end
      // rotation keeps the population of valid stages constant
      if (!recirc)
        cnt <= cnt + CW'(d_valid) - CW'(vld[DEPTH-1]);
    end
  end

  always_comb begin
    tap_q     = RESET_VAL;
    tap_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TSW'(i)) begin
        tap_q     = data[i];
        tap_valid = vld[i];
      end
    end
  end

  assign q        = data[DEPTH-1];
  assign q_valid  = vld[DEPTH-1];
  assign fill_cnt = cnt;
  assign full     = (cnt == CW'(DEPTH));

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: DEPTH=4 main instance plus a DEPTH=3
// instance for the out-of-range tap.
module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic       recirc = 1'b0;
  logic [7:0] d = '0;
  logic       d_valid = 1'b0;
  logic [1:0] tap_sel = '0;
  logic [1:0] tap_sel3 = '0;

  logic [7:0] q, tap_q, q3, tap_q3;
  logic       q_valid, tap_valid, full;
  logic       q_valid3, tap_valid3, full3;
  logic [2:0] fill_cnt;
  logic [1:0] fill_cnt3;

  int total = 0;
  int passed = 0;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .clear(clear),
    .recirc(recirc), .d(d), .d_valid(d_valid), .tap_sel(tap_sel),
    .q(q), .q_valid(q_valid), .tap_q(tap_q), .tap_valid(tap_valid),
    .fill_cnt(fill_cnt), .full(full)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut3 (
    .clk(clk), .reset(reset), .en(en), .clear(clear),
    .recirc(recirc), .d(d), .d_valid(d_valid), .tap_sel(tap_sel3),
    .q(q3), .q_valid(q_valid3), .tap_q(tap_q3), .tap_valid(tap_valid3),
    .fill_cnt(fill_cnt3), .full(full3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_q", 64'(q), 64'h0);
    chk("rst_qv", 64'(q_valid), 64'h0);
    chk("rst_fill", 64'(fill_cnt), 64'h0);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_tapv", 64'(tap_valid), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    en = 1'b1; d_valid = 1'b1;
    d = 8'h11; step();
    chk("fill1_cnt", 64'(fill_cnt), 64'h1);
    d = 8'h22; step();
    d = 8'h33; step();
    chk("fill3_qv", 64'(q_valid), 64'h0);
    d = 8'h44; step();
    chk("fill_q", 64'(q), 64'h11);
    chk("fill_qv", 64'(q_valid), 64'h1);
    chk("fill_full", 64'(full), 64'h1);
    chk("fill_cnt", 64'(fill_cnt), 64'h4);
    tap_sel = 2'd0; #1;
    chk("fill_tap0", 64'(tap_q), 64'h44);
    tap_sel = 2'd2; #1;
    chk("fill_tap2", 64'(tap_q), 64'h22);
    tap_sel = 2'd3; #1;
    chk("tap3_eq_q", 64'(tap_q), 64'h11);

    en = 1'b0; d = 8'hAA; d_valid = 1'b1;
    step(); step(); step();
    chk("hold_q", 64'(q), 64'h11);
    chk("hold_cnt", 64'(fill_cnt), 64'h4);
    tap_sel = 2'd0; #1;
    chk("hold_tap0", 64'(tap_q), 64'h44);

    en = 1'b1; d = 8'h55; d_valid = 1'b0;
    step();
    chk("bub1_cnt", 64'(fill_cnt), 64'h3);
    step();
    chk("bub_q", 64'(q), 64'h33);
    chk("bub_cnt", 64'(fill_cnt), 64'h2);
    chk("bub_full", 64'(full), 64'h0);
    tap_sel = 2'd1; #1;
    chk("bub_tap1", 64'(tap_q), 64'h55);
    chk("bub_tapv1", 64'(tap_valid), 64'h0);

    clear = 1'b1; en = 1'b1; d = 8'hFF; d_valid = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_q", 64'(q), 64'h0);
    chk("clr_qv", 64'(q_valid), 64'h0);
    chk("clr_cnt", 64'(fill_cnt), 64'h0);
    for (int i = 0; i < 4; i++) begin
      tap_sel = 2'(i); #1;
      chk("clr_tap", 64'(tap_q), 64'h0);
    end

    d_valid = 1'b1;
    d = 8'h11; step();
    d = 8'h22; step();
    d = 8'h33; step();
    d = 8'h44; step();
    chk("refill_q", 64'(q), 64'h11);

    recirc = 1'b1; d = 8'hEE; d_valid = 1'b0;
    step();
    chk("rot1_q", 64'(q), 64'h22);
    chk("rot1_cnt", 64'(fill_cnt), 64'h4);
    step();
    chk("rot2_q", 64'(q), 64'h33);
    step();
    chk("rot3_q", 64'(q), 64'h44);
    step();
    chk("rot4_q", 64'(q), 64'h11);
    chk("rot4_cnt", 64'(fill_cnt), 64'h4);
    tap_sel = 2'd0; #1;
    chk("rot4_tap0", 64'(tap_q), 64'h44);

    recirc = 1'b0; d = 8'h66; d_valid = 1'b1;
    step();
    chk("full_acc_q", 64'(q), 64'h22);
    chk("full_acc_cnt", 64'(fill_cnt), 64'h4);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_q", 64'(q), 64'h0);
    chk("arst_qv", 64'(q_valid), 64'h0);
    chk("arst_cnt", 64'(fill_cnt), 64'h0);
    chk("arst_full", 64'(full), 64'h0);
    chk("arst_tap", 64'(tap_q), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    d = 8'h77; step();
    d = 8'h88; step();
    d = 8'h99; step();
    chk("re3_qv", 64'(q_valid), 64'h0);
    chk("re3_cnt", 64'(fill_cnt), 64'h3);
    d = 8'hAA; step();
    chk("re_q", 64'(q), 64'h77);
    chk("re_cnt", 64'(fill_cnt), 64'h4);

    tap_sel3 = 2'd2; #1;
    chk("d3_tap2", 64'(tap_q3), 64'h88);
    chk("d3_tapv2", 64'(tap_valid3), 64'h1);
    tap_sel3 = 2'd3; #1;
    chk("d3_tap3", 64'(tap_q3), 64'h0);
    chk("d3_tapv3", 64'(tap_valid3), 64'h0);
    chk("d3_full", 64'(full3), 64'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data bits per stage (legal 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 4, number of register stages (legal 1..64).
REQ-003 The block SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into every stage on reset or clear.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: advance enable; 0 means every stage holds.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous clear.
REQ-008 The block SHALL have port recirc, input, 1 bit: when 1 with en, rotate the pipeline instead of loading d.
REQ-009 The block SHALL have port d, input, WIDTH bits: data into stage 0.
REQ-010 The block SHALL have port d_valid, input, 1 bit: marks d as valid.
REQ-011 The block SHALL have port tap_sel, input, TSW = max(1, clog2(DEPTH)) bits: selects the stage driven onto tap_q.
REQ-012 The block SHALL have port q, output, WIDTH bits: stage DEPTH-1 data.
REQ-013 The block SHALL have port q_valid, output, 1 bit: valid flag of stage DEPTH-1.
REQ-014 The block SHALL have port tap_q, output, WIDTH bits: data of the stage selected by tap_sel.
REQ-015 The block SHALL have port tap_valid, output, 1 bit: valid flag of the stage selected by tap_sel.
REQ-016 The block SHALL have port fill_cnt, output, clog2(DEPTH+1) bits: number of stages holding valid data.
REQ-017 The block SHALL have port full, output, 1 bit: asserted when fill_cnt equals DEPTH.

Function
REQ-018 Each stage i SHALL hold a WIDTH-bit data register and a 1-bit valid register.
REQ-019 Priority at each clock edge SHALL be reset > clear > en.
REQ-020 When en=1 and recirc=0, the block SHALL load stage0 <= d and valid0 <= d_valid, and stage i <= stage i-1 for i = 1..DEPTH-1 (data and valid together).
REQ-021 When en=1 and recirc=1, stage0 SHALL take the old stage DEPTH-1 data and valid, and the other stages SHALL shift as in REQ-020; d and d_valid are ignored.
REQ-022 When en=0 and clear=0, all stages, valids and fill_cnt SHALL hold.
REQ-023 With recirc=0, latency SHALL be DEPTH enabled edges: d presented at enabled edge n appears on q after enabled edge n+DEPTH-1, i.e. q follows d after DEPTH enabled edges in total; disabled edges do not count.
REQ-024 fill_cnt SHALL be registered.
REQ-025 On an enabled non-recirc edge, fill_cnt SHALL update to fill_cnt + d_valid - q_valid (old value); it never exceeds DEPTH and never underflows.
REQ-026 On an enabled recirc edge, fill_cnt SHALL be unchanged.
REQ-027 full SHALL be combinational from fill_cnt.
REQ-028 When tap_sel < DEPTH, tap_q and tap_valid SHALL be combinational reads of stage tap_sel; tap_sel = DEPTH-1 equals q/q_valid.
REQ-029 When tap_sel >= DEPTH, tap_q SHALL be RESET_VAL and tap_valid SHALL be 0.
REQ-030 A synchronous clear SHALL set all stages to RESET_VAL, all valids to 0 and fill_cnt to 0, regardless of en, recirc or d_valid.
REQ-031 With DEPTH=1, the block SHALL behave as a single enabled register: q follows d one enabled edge later, recirc holds its value, and fill_cnt is 0 or 1.
REQ-032 When full=1, the block SHALL still accept input; the oldest entry leaves on q with no back-pressure.

Reset
REQ-033 While reset=1, all stages SHALL equal RESET_VAL, all valids 0, and fill_cnt 0, immediately and without waiting for clk.
REQ-034 A reset asserted mid-operation SHALL discard all contents asynchronously.
REQ-035 The first update after reset deasserts SHALL occur at the first rising clk edge on which reset is low.
REQ-036 Outputs q, q_valid, tap_q, tap_valid and full SHALL reflect the reset state combinationally.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=0)
REQ-037 Basic fill: the bench SHALL pulse reset, then on 4 enabled edges apply d = 0x11, 0x22, 0x33, 0x44 with d_valid=1; the required response is q=0x11, q_valid=1, full=1, fill_cnt=4, and tap_sel=0 gives tap_q=0x44.
REQ-038 Hold and bubbles: the bench SHALL drop en for 3 cycles, then apply d_valid=0 for 2 enabled edges; the required response is no change while en=0, then q=0x33, fill_cnt=2 after the two bubble edges.
REQ-039 Recirc: from full 0x11..0x44, the bench SHALL apply recirc=1 for 4 enabled edges; the required response is q sequencing 0x22, 0x33, 0x44, 0x11, with fill_cnt held at 4.
REQ-040 Clear vs en: the bench SHALL assert clear and en together with d=0xFF, d_valid=1; the required response is all stages 0, fill_cnt=0, q_valid=0.
REQ-041 Async reset mid-stream: the bench SHALL raise reset between clock edges; the required response is q=0 and fill_cnt=0 before the next rising edge, and the pipeline refills normally after release.
REQ-042 Tap out of range: the bench SHALL build with DEPTH=3 and drive tap_sel=3; the required response is tap_q=0 and tap_valid=0.
